inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter QDEPTH, default 2, SHALL set the number of instruction-queue entries (legal range 1-8).
REQ-002 Parameter IMEM_AW, default 5, SHALL set the byte-address width of the instruction memory (32 bytes).
REQ-003 Parameter RESET_PC, default 32'h0, SHALL set the fetch PC loaded on reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 imem_en  output  1  SHALL mark a byte read this cycle.
REQ-007 imem_addr  output  IMEM_AW  SHALL carry the byte address.
REQ-008 imem_rdata  input  8  SHALL carry the byte at imem_addr, valid combinationally in the same cycle.
REQ-009 inst_valid  output  1  SHALL mark that inst and inst_pc hold a queued word.
REQ-010 inst_ready  input  1  SHALL be the consumer acceptance; a transfer occurs when inst_valid and inst_ready are both 1.
REQ-011 inst  output  32  SHALL carry the head instruction word.
REQ-012 inst_pc  output  32  SHALL carry the byte PC of the head instruction.
REQ-013 redirect  input  1  SHALL request a flush and a fetch restart.
REQ-014 redirect_pc  input  32  SHALL carry the restart PC; bits [1:0] are ignored.

Function
REQ-015 FSM states SHALL be B0, B1, B2, B3: one byte per state, byte index 0-3.
- B0: if queue count < QDEPTH, imem_en=1 and advance to B1; otherwise imem_en=0 and hold in B0.
- B1, B2: imem_en=1, advance unconditionally.
- B3: imem_en=1, push the assembled word, return to B0.
REQ-016 imem_addr SHALL equal (fetch_pc + byte index) truncated to IMEM_AW bits; address wrap-around is silent.
REQ-017 Word assembly SHALL be big-endian: byte index 0 goes to inst[31:24] and byte index 3 goes to inst[7:0].
REQ-018 On push, fetch_pc SHALL be stored as the entry PC and then advance by 4, modulo 2^32.
REQ-019 Entering B0 only when count < QDEPTH SHALL guarantee space at B3; a push never meets a full queue.
REQ-020 The queue SHALL be FIFO. With push and pop in the same cycle, count is unchanged and order is preserved.
REQ-021 inst_valid SHALL equal (count != 0). inst and inst_pc SHALL be registered head contents, and SHALL read 0 when empty.
REQ-022 Latency SHALL be as follows.
- After reset or redirect, the first word is pushed at the end of the 4th fetch cycle, and inst_valid rises in the 5th cycle.
- Sustained throughput is one word per 4 cycles.
REQ-023 Redirect SHALL take priority over all fetch activity in its cycle.
- Queue flushed (count=0) and the partial word discarded.
- fetch_pc set to {redirect_pc[31:2],2'b00}; state goes to B0.
- Any push in that cycle is dropped.
- A transfer accepted in the redirect cycle still counts as consumed.
REQ-024 While inst_valid=1 and inst_ready=0, inst and inst_pc SHALL remain stable.
REQ-025 fetch_pc wrap from 32'hFFFFFFFC SHALL go to 32'h0.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL enter its reset state.
- Registers: state=B0, fetch_pc=RESET_PC, count=0, queue pointers=0, assembly register=0.
- Outputs: inst_valid=0, inst=0, inst_pc=0, imem_en=0.
REQ-027 rst SHALL override redirect and any in-progress word. imem_en SHALL be 0 during the reset cycle.

Structure
REQ-028 Package proc_pkg SHALL hold the FSM state enum, INST_W=32, and the RESET_PC default.
REQ-029 The queue SHALL be a sub-module fetch_queue with these ports: push, push_data, push_pc, pop, flush, count, head.
REQ-030 Byte assembly, the FSM and fetch_pc SHALL reside in inst_fetch_unit.

Verification
REQ-031 Reset, then memory bytes 0-7 = 20 01 00 04 20 02 00 08 with inst_ready=1 -> inst=32'h20010004, inst_pc=0 in cycle 5; inst=32'h20020008, inst_pc=4 in cycle 9.
REQ-032 inst_ready=0 for 20 cycles with QDEPTH=2 -> count saturates at 2, imem_en stays 0 in B0, head is stable at pc 0; raise inst_ready -> both words drain in order, then fetch resumes.
REQ-033 Redirect to 32'h00000012 during B2 of the word at pc 4 -> queue empties next cycle; next fetch addresses 10,11,12,13; first word has inst_pc=32'h10.
REQ-034 IMEM_AW=5 with fetch_pc=32'h1C -> imem_addr runs 1C,1D,1E,1F; next word fetch runs 00..03; inst_pc=32'h20.
REQ-035 rst asserted during B1 while redirect=1 -> next cycle state=B0, fetch_pc=RESET_PC, inst_valid=0.
REQ-036 Push and pop in the same cycle with count=1 -> count stays 1 and the head becomes the new word.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and constants for the instruction fetch path.
package proc_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Fetch FSM: the state value doubles as the byte index within the word.
  // state | meaning
  // B0    | fetch byte 0 if the queue has room, else idle
  // B1    | fetch byte 1
  // B2    | fetch byte 2
  // B3    | fetch byte 3 and push the assembled word
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] word;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched words with their PCs; head reads 0 when empty.
module fetch_queue
  import proc_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [INST_W-1:0]   push_data,
  input  logic [INST_W-1:0]   push_pc,
  input  logic                pop,
  input  logic                flush,
  output logic [CNT_W-1:0]    count,
  output fq_entry_t           head
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fq_entry_t        r_mem [QDEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_do_pop;
  logic [PTR_W-1:0] w_rd_ptr_inc;
  logic [PTR_W-1:0] w_wr_ptr_inc;

  assign w_do_pop = pop && (r_count != '0);

  // Pointer increment with wrap at QDEPTH (depth need not be a power of two).
  always_comb begin
    w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
    w_wr_ptr_inc = r_wr_ptr + PTR_W'(1);
    if (r_rd_ptr == PTR_W'(QDEPTH - 1)) w_rd_ptr_inc = '0;
    if (r_wr_ptr == PTR_W'(QDEPTH - 1)) w_wr_ptr_inc = '0;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue and drops any push.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)     r_wr_ptr <= w_wr_ptr_inc;
      if (w_do_pop) r_rd_ptr <= w_rd_ptr_inc;
      unique case ({push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only visible through head while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      r_mem[r_wr_ptr].pc   <= push_pc;
      r_mem[r_wr_ptr].word <= push_data;
    end
  end

  assign count = r_count;
  assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// Byte-serial instruction fetch: four big-endian byte reads per word, queued for the consumer.
module inst_fetch_unit
  import proc_pkg::*;
#(
  parameter int          QDEPTH   = 2,
  parameter int          IMEM_AW  = 5,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [7:0]          imem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_W-1:0]   inst,
  output logic [INST_W-1:0]   inst_pc,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [31:0]      r_fetch_pc;
  logic [23:0]      r_asm;

  logic             w_imem_en;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count;
  fq_entry_t        w_head;
  logic [31:0]      w_redirect_pc;

  // Masking keeps the alignment explicit and uses every bit of the input.
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  // Next-state and fetch strobes; redirect and then reset override everything.
  always_comb begin
    w_state_nxt = r_state;
    w_imem_en   = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      B0: begin
        if (w_count < CNT_W'(QDEPTH)) begin
          w_imem_en   = 1'b1;
          w_state_nxt = B1;
        end
      end
      B1: begin
        w_imem_en   = 1'b1;
        w_state_nxt = B2;
      end
      B2: begin
        w_imem_en   = 1'b1;
        w_state_nxt = B3;
      end
      B3: begin
        w_imem_en   = 1'b1;
        w_push      = 1'b1;
        w_state_nxt = B0;
      end
      default: w_state_nxt = B0;
    endcase
    if (redirect) begin
      w_imem_en   = 1'b0;
      w_push      = 1'b0;
      w_state_nxt = B0;
    end
    if (rst) begin
      w_imem_en   = 1'b0;
      w_push      = 1'b0;
      w_state_nxt = B0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= B0;
    else     r_state <= w_state_nxt;
  end

  // Fetch PC and byte assembly; bytes 0-2 shift in so byte 0 ends up most significant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_asm      <= '0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_asm      <= '0;
    end else begin
      if (w_imem_en && (r_state != B3)) r_asm <= {r_asm[15:0], imem_rdata};
      if (w_push)                       r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  assign imem_en   = w_imem_en;
  assign imem_addr = r_fetch_pc[IMEM_AW-1:0] + IMEM_AW'(r_state);

  assign inst_valid = (w_count != '0);
  assign w_pop      = inst_valid && inst_ready;

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .CNT_W  (CNT_W)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({r_asm, imem_rdata}),
    .push_pc   (r_fetch_pc),
    .pop       (w_pop),
    .flush     (redirect),
    .count     (w_count),
    .head      (w_head)
  );

  assign inst    = w_head.word;
  assign inst_pc = w_head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 32-byte combinational memory model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [4:0]  imem_addr;
  logic [7:0]  imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [7:0]  mem [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  inst_fetch_unit #(
    .QDEPTH   (2),
    .IMEM_AW  (5),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Holds reset over several edges, checks reset outputs, and releases it
  // right after an edge so the following interval is fetch cycle 1.
  task automatic do_reset(input logic rdy);
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = rdy;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_en", {31'b0, imem_en}, 32'h0);
    next_cyc();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
    mem[0] = 8'h20; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
    mem[4] = 8'h20; mem[5] = 8'h02; mem[6] = 8'h00; mem[7] = 8'h08;

    // Basic fetch with consumer always ready.
    do_reset(1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      case (c)
        1: begin
          chk("t1_c1_en", {31'b0, imem_en}, 32'h1);
          chk("t1_c1_addr", {27'b0, imem_addr}, 32'h0);
        end
        4: chk("t1_c4_addr", {27'b0, imem_addr}, 32'h3);
        5: begin
          chk("t1_c5_valid", {31'b0, inst_valid}, 32'h1);
          chk("t1_c5_inst", inst, 32'h2001_0004);
          chk("t1_c5_pc", inst_pc, 32'h0);
        end
        6: chk("t1_c6_valid", {31'b0, inst_valid}, 32'h0);
        9: begin
          chk("t1_c9_inst", inst, 32'h2002_0008);
          chk("t1_c9_pc", inst_pc, 32'h4);
        end
        default: ;
      endcase
      next_cyc();
    end

    // Backpressure: queue fills to two, fetch idles, then drains in order.
    do_reset(1'b0);
    for (int c = 1; c <= 26; c++) begin
      if (c == 21) inst_ready = 1'b1;
      @(negedge clk);
      case (c)
        12: chk("t2_c12_en", {31'b0, imem_en}, 32'h0);
        20: begin
          chk("t2_c20_en", {31'b0, imem_en}, 32'h0);
          chk("t2_c20_valid", {31'b0, inst_valid}, 32'h1);
          chk("t2_c20_inst", inst, 32'h2001_0004);
          chk("t2_c20_pc", inst_pc, 32'h0);
        end
        21: begin
          chk("t2_c21_pc", inst_pc, 32'h0);
          chk("t2_c21_en", {31'b0, imem_en}, 32'h0);
        end
        22: begin
          chk("t2_c22_pc", inst_pc, 32'h4);
          chk("t2_c22_inst", inst, 32'h2002_0008);
          chk("t2_c22_en", {31'b0, imem_en}, 32'h1);
          chk("t2_c22_addr", {27'b0, imem_addr}, 32'h8);
        end
        23: chk("t2_c23_valid", {31'b0, inst_valid}, 32'h0);
        26: begin
          chk("t2_c26_inst", inst, 32'hA8A9_AAAB);
          chk("t2_c26_pc", inst_pc, 32'h8);
        end
        default: ;
      endcase
      next_cyc();
    end

    // Redirect to 0x12 during B2 of the word at pc 4.
    do_reset(1'b0);
    for (int c = 1; c <= 12; c++) begin
      redirect    = (c == 7);
      redirect_pc = 32'h0000_0012;
      @(negedge clk);
      case (c)
        7:  chk("t3_c7_valid", {31'b0, inst_valid}, 32'h1);
        8: begin
          chk("t3_c8_valid", {31'b0, inst_valid}, 32'h0);
          chk("t3_c8_en", {31'b0, imem_en}, 32'h1);
          chk("t3_c8_addr", {27'b0, imem_addr}, 32'h10);
        end
        9:  chk("t3_c9_addr", {27'b0, imem_addr}, 32'h11);
        10: chk("t3_c10_addr", {27'b0, imem_addr}, 32'h12);
        11: chk("t3_c11_addr", {27'b0, imem_addr}, 32'h13);
        12: begin
          chk("t3_c12_inst", inst, 32'hB0B1_B2B3);
          chk("t3_c12_pc", inst_pc, 32'h10);
        end
        default: ;
      endcase
      next_cyc();
    end
    redirect = 1'b0;

    // Address wrap: fetch from 0x1C, next word addresses wrap to 0 with pc 0x20.
    do_reset(1'b1);
    for (int c = 1; c <= 10; c++) begin
      redirect    = (c == 1);
      redirect_pc = 32'h0000_001C;
      @(negedge clk);
      case (c)
        2:  chk("t4_c2_addr", {27'b0, imem_addr}, 32'h1C);
        5:  chk("t4_c5_addr", {27'b0, imem_addr}, 32'h1F);
        6: begin
          chk("t4_c6_inst", inst, 32'hBCBD_BEBF);
          chk("t4_c6_pc", inst_pc, 32'h1C);
          chk("t4_c6_addr", {27'b0, imem_addr}, 32'h0);
        end
        9:  chk("t4_c9_addr", {27'b0, imem_addr}, 32'h3);
        10: begin
          chk("t4_c10_inst", inst, 32'h2001_0004);
          chk("t4_c10_pc", inst_pc, 32'h20);
        end
        default: ;
      endcase
      next_cyc();
    end
    redirect = 1'b0;

    // Reset during B1 with redirect also asserted: reset wins.
    do_reset(1'b0);
    for (int c = 1; c <= 7; c++) begin
      rst         = (c == 6);
      redirect    = (c == 6);
      redirect_pc = 32'h0000_0040;
      @(negedge clk);
      case (c)
        5: chk("t5_c5_valid", {31'b0, inst_valid}, 32'h1);
        6: chk("t5_c6_en", {31'b0, imem_en}, 32'h0);
        7: begin
          chk("t5_c7_valid", {31'b0, inst_valid}, 32'h0);
          chk("t5_c7_en", {31'b0, imem_en}, 32'h1);
          chk("t5_c7_addr", {27'b0, imem_addr}, 32'h0);
          chk("t5_c7_pc", inst_pc, 32'h0);
        end
        default: ;
      endcase
      next_cyc();
    end
    rst      = 1'b0;
    redirect = 1'b0;

    // Push and pop together at count 1: head becomes the new word, count stays 1.
    do_reset(1'b0);
    for (int c = 1; c <= 11; c++) begin
      inst_ready = (c == 8) || (c == 10);
      @(negedge clk);
      case (c)
        8: begin
          chk("t6_c8_valid", {31'b0, inst_valid}, 32'h1);
          chk("t6_c8_pc", inst_pc, 32'h0);
        end
        9: begin
          chk("t6_c9_valid", {31'b0, inst_valid}, 32'h1);
          chk("t6_c9_inst", inst, 32'h2002_0008);
          chk("t6_c9_pc", inst_pc, 32'h4);
        end
        10: chk("t6_c10_pc", inst_pc, 32'h4);
        11: begin
          chk("t6_c11_valid", {31'b0, inst_valid}, 32'h0);
          chk("t6_c11_inst", inst, 32'h0);
        end
        default: ;
      endcase
      next_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
